// File: rtl/div_pkg.sv
// div_pkg: slice/address widths, readout FSM states and the {plus, minus} RAM word shared by the division datapath.
package div_pkg;
  localparam int SLICE_W = 4;
  localparam int ADDR_W  = 7;
  typedef enum logic [2:0] {IDLE, FETCH, CALC, SEND, FIN} state_e;
  typedef struct packed {
    logic [SLICE_W-1:0] plus;
    logic [SLICE_W-1:0] minus;
  } ram_word_t;
endpackage

// File: rtl/slice_sub_borrow.sv
// slice_sub_borrow: one-slice subtract with borrow, {bout, diff} = plus - minus - bin.
module slice_sub_borrow
  import div_pkg::*;
(
  input  logic [SLICE_W-1:0] plus_i,
  input  logic [SLICE_W-1:0] minus_i,
  input  logic               bin_i,
  output logic [SLICE_W-1:0] diff_o,
  output logic               bout_o
);
  assign {bout_o, diff_o} = {1'b0, plus_i} - {1'b0, minus_i} - {{SLICE_W{1'b0}}, bin_i};
endmodule

// File: rtl/residue_readout.sv
// residue_readout: streams redundant residue slices from the w-value RAM as a two's-complement remainder,
// least-significant slice first, with final sign/zero flags.
module residue_readout
  import div_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    num_slices_i,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [2*SLICE_W-1:0] rd_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [SLICE_W-1:0]   out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sign_o,
  output logic                 zero_o
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, n_q, n_d, addr_q, addr_d;
  logic [SLICE_W-1:0]  data_q, data_d, diff;
  logic                borrow_q, borrow_d, zacc_q, zacc_d, sign_q, sign_d, zero_q, zero_d;
  logic                last_q, last_d, bout;
  ram_word_t           word;

  assign word = rd_data_i;

  slice_sub_borrow u_sub (
    .plus_i (word.plus),
    .minus_i(word.minus),
    .bin_i  (borrow_q),
    .diff_o (diff),
    .bout_o (bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    addr_d   = addr_q;
    data_d   = data_q;
    borrow_d = borrow_q;
    zacc_d   = zacc_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    last_d   = last_q;
    case (state_q)
      IDLE: if (start_i) begin
        n_d      = num_slices_i;
        idx_d    = '0;
        borrow_d = 1'b0;
        zacc_d   = 1'b1;
        sign_d   = 1'b0;
        zero_d   = (num_slices_i == '0);
        state_d  = (num_slices_i == '0) ? FIN : FETCH;
      end
      FETCH: begin
        addr_d  = idx_q;
        state_d = CALC;
      end
      CALC: begin
        data_d   = diff;
        borrow_d = bout;
        zacc_d   = zacc_q & (diff == '0);
        last_d   = (idx_q == n_q - ADDR_W'(1));
        state_d  = SEND;
      end
      SEND: if (out_ready_i) begin
        if (last_q) begin
          sign_d  = borrow_q;
          zero_d  = zacc_q;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      borrow_q <= 1'b0;
      zacc_q   <= 1'b1;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      last_q   <= last_d;
    end
  end

  // Outputs decode only registered state, so out_ready never reaches them combinationally.
  assign rd_en_o     = (state_q == FETCH);
  assign rd_addr_o   = rd_en_o ? idx_q : addr_q;
  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FIN);
  assign sign_o      = sign_q;
  assign zero_o      = zero_q;
endmodule

// File: tb/tb_residue_readout.sv
// tb_residue_readout: randomized and directed runs of residue_readout against a big-number subtraction model.
module tb_residue_readout;
  logic       clk = 1'b0;
  logic       rst_n, start, out_ready;
  logic [6:0] num;
  logic       rd_en, out_valid, out_last, busy, done, sign, zero;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] out_data;

  logic [7:0] mem [128];
  logic [4:0] got[$], exp_q[$];
  bit         exp_sign, exp_zero, got_sign, got_zero, busy_after, timeout, stable_ok;
  int         done_cyc, reads, rd_in_send, stalls;
  int         vecs = 0, errs = 0;

  residue_readout dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_slices_i(num),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy), .done_o(done), .sign_o(sign), .zero_o(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // Remainder = (sum of plus slices) - (sum of minus slices) as plain integers.
  function automatic void model(input int n);
    longint p = 0, m = 0;
    logic [63:0] r;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      p += longint'(mem[i][7:4]) << (4 * i);
      m += longint'(mem[i][3:0]) << (4 * i);
    end
    r = 64'(p - m);
    exp_sign = (p < m);
    exp_zero = (p == m);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, r[4*i +: 4]});
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
  endtask

  task automatic drive_run(input int n, input int stall_pct, input int hold, input bit pulse);
    int vcnt = 0;
    bit pv = 0, pa = 0;
    logic [4:0] pd = '0;
    got.delete();
    reads = 0; stalls = 0; rd_in_send = 0; stable_ok = 1; timeout = 1; done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; num = 7'(n); out_ready = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      start = pulse && out_valid;
      num = 7'($urandom_range(127));
      out_ready = (vcnt >= hold) && ($urandom_range(99) >= stall_pct);
      if (rd_en) reads++;
      if (rd_en && out_valid) rd_in_send++;
      if (out_valid && pv && !pa && {out_last, out_data} !== pd) stable_ok = 0;
      if (out_valid && !out_ready) stalls++;
      if (out_valid) vcnt++;
      pv = out_valid;
      pa = out_valid && out_ready;
      pd = {out_last, out_data};
      if (pa) begin got.push_back(pd); vcnt = 0; end
      if (done) begin done_cyc = cyc; got_sign = sign; got_zero = zero; timeout = 0; break; end
    end
    start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    #1;
    vecs++;
    if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done, sign, zero} !== 18'd0) begin
      errs++; $display("FAIL reset_outputs: got %h want 0", {rd_en, rd_addr, out_valid, out_data, out_last, busy, done, sign, zero});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if ({busy, out_valid, rd_en, done} !== 4'd0) begin errs++; $display("FAIL idle_after_reset: got %b want 0000", {busy, out_valid, rd_en, done}); end
  endtask

  task automatic test_two_slice;
    mem[0] = 8'h35; mem[1] = 8'h00;
    drive_run(2, 0, 0, 0);
    vecs++; if (got.size() !== 2) begin errs++; $display("FAIL n2_count: got %0d want 2", got.size()); end
    vecs++; if (got[0] !== 5'h0E) begin errs++; $display("FAIL n2_beat0: got %h want 0e", got[0]); end
    vecs++; if (got[1] !== 5'h1F) begin errs++; $display("FAIL n2_beat1: got %h want 1f", got[1]); end
    vecs++; if ({got_sign, got_zero} !== 2'b10) begin errs++; $display("FAIL n2_flags: got %b want 10", {got_sign, got_zero}); end
    vecs++; if (done_cyc !== 7) begin errs++; $display("FAIL n2_done_cycle: got %0d want 7", done_cyc); end
    vecs++; if (busy_after !== 1'b0) begin errs++; $display("FAIL n2_busy_fall: got %b want 0", busy_after); end
    vecs++; if ({sign, zero} !== 2'b10) begin errs++; $display("FAIL n2_flags_held: got %b want 10", {sign, zero}); end
  endtask

  task automatic test_equal;
    for (int i = 0; i < 3; i++) mem[i] = 8'hAA;
    drive_run(3, 0, 0, 0);
    vecs++; if (got.size() !== 3) begin errs++; $display("FAIL eq_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (got[i] !== {i == 2, 4'h0}) begin errs++; $display("FAIL eq_beat%0d: got %h want %h", i, got[i], {i == 2, 4'h0}); end
    end
    vecs++; if ({got_sign, got_zero} !== 2'b01) begin errs++; $display("FAIL eq_flags: got %b want 01", {got_sign, got_zero}); end
    vecs++; if (done_cyc !== 10) begin errs++; $display("FAIL eq_done_cycle: got %0d want 10", done_cyc); end
  endtask

  task automatic test_stall;
    mem[0] = 8'h72;
    drive_run(1, 0, 5, 0);
    vecs++; if (got.size() !== 1 || got[0] !== 5'h15) begin errs++; $display("FAIL stall_beat: got %h want 15", got[0]); end
    vecs++; if (stable_ok !== 1'b1) begin errs++; $display("FAIL stall_stable: got %b want 1", stable_ok); end
    vecs++; if (rd_in_send !== 0) begin errs++; $display("FAIL stall_no_read: got %0d want 0", rd_in_send); end
    vecs++; if (stalls !== 5) begin errs++; $display("FAIL stall_cycles: got %0d want 5", stalls); end
    vecs++; if (done_cyc !== 9) begin errs++; $display("FAIL stall_done_cycle: got %0d want 9", done_cyc); end
    vecs++; if ({got_sign, got_zero} !== 2'b00) begin errs++; $display("FAIL stall_flags: got %b want 00", {got_sign, got_zero}); end
  endtask

  task automatic test_zero_len;
    drive_run(0, 0, 0, 0);
    vecs++; if (reads !== 0) begin errs++; $display("FAIL n0_reads: got %0d want 0", reads); end
    vecs++; if (got.size() !== 0) begin errs++; $display("FAIL n0_beats: got %0d want 0", got.size()); end
    vecs++; if (done_cyc !== 1) begin errs++; $display("FAIL n0_done_cycle: got %0d want 1", done_cyc); end
    vecs++; if ({got_sign, got_zero} !== 2'b01) begin errs++; $display("FAIL n0_flags: got %b want 01", {got_sign, got_zero}); end
  endtask

  task automatic test_start_ignored;
    fill_random(2);
    model(2);
    drive_run(2, 40, 0, 1);
    vecs++; if (got.size() !== 2) begin errs++; $display("FAIL ign_count: got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (got[i] !== exp_q[i]) begin errs++; $display("FAIL ign_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    vecs++; if ({got_sign, got_zero} !== {exp_sign, exp_zero}) begin errs++; $display("FAIL ign_flags: got %b want %b", {got_sign, got_zero}, {exp_sign, exp_zero}); end
    vecs++; if (done_cyc !== 7 + stalls) begin errs++; $display("FAIL ign_done_cycle: got %0d want %0d", done_cyc, 7 + stalls); end
  endtask

  task automatic test_reset_mid;
    mem[0] = 8'h91; mem[1] = 8'h10; mem[2] = 8'h01;
    @(posedge clk); #1; start = 1'b1; num = 7'd3;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({rd_en, rd_addr, out_valid, out_data, out_last, busy, done, sign, zero} !== 18'd0) begin
      errs++; $display("FAIL mid_reset_outputs: got %h want 0", {rd_en, rd_addr, out_valid, out_data, out_last, busy, done, sign, zero});
    end
    @(negedge clk) rst_n = 1'b1;
    fill_random(3);
    model(3);
    drive_run(3, 20, 0, 0);
    vecs++; if (got.size() !== 3) begin errs++; $display("FAIL mid_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (got[i] !== exp_q[i]) begin errs++; $display("FAIL mid_beat%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    vecs++; if ({got_sign, got_zero} !== {exp_sign, exp_zero}) begin errs++; $display("FAIL mid_flags: got %b want %b", {got_sign, got_zero}, {exp_sign, exp_zero}); end
  endtask

  task automatic test_random;
    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(12, 1);
      fill_random(n);
      if (t % 5 == 0) for (int i = 0; i < n; i++) mem[i][7:4] = mem[i][3:0];
      model(n);
      drive_run(n, 30, 0, t[0]);
      vecs++; if (timeout) begin errs++; $display("FAIL rnd%0d_timeout: got no done want done", t); end
      vecs++; if (got.size() !== n) begin errs++; $display("FAIL rnd%0d_count: got %0d want %0d", t, got.size(), n); end
      for (int i = 0; i < n; i++) begin
        vecs++;
        if (got[i] !== exp_q[i]) begin errs++; $display("FAIL rnd%0d_beat%0d: got %h want %h", t, i, got[i], exp_q[i]); end
      end
      vecs++; if ({got_sign, got_zero} !== {exp_sign, exp_zero}) begin errs++; $display("FAIL rnd%0d_flags: got %b want %b", t, {got_sign, got_zero}, {exp_sign, exp_zero}); end
      vecs++; if (done_cyc !== 3 * n + 1 + stalls) begin errs++; $display("FAIL rnd%0d_done_cycle: got %0d want %0d", t, done_cyc, 3 * n + 1 + stalls); end
      vecs++; if (reads !== n || rd_in_send !== 0) begin errs++; $display("FAIL rnd%0d_reads: got %0d/%0d want %0d/0", t, reads, rd_in_send, n); end
      vecs++; if (stable_ok !== 1'b1 || busy_after !== 1'b0) begin errs++; $display("FAIL rnd%0d_stable_busy: got %b%b want 10", t, stable_ok, busy_after); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num = '0; out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset;
    test_two_slice;
    test_equal;
    test_stall;
    test_zero_len;
    test_start_ignored;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/residue_readout.md
# residue_readout

Reads the redundant (plus/minus) partial-residue slices that the division datapath stores in the w-value RAM and converts them, least-significant slice first, into a non-redundant two's-complement remainder stream. It sits on the RAM read port after a division completes. It emits one 4-bit slice per handshake beat, plus final sign and zero flags for remainder correction and termination logic.

## Interface
- SLICE_W, 4, digit-slice width. Each of plus and minus is SLICE_W bits; a RAM word is 2*SLICE_W bits.
- ADDR_W, 7, RAM address width. Matches the computation_cycle width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- num_slices  in  ADDR_W  number of slices to read; sampled when start is accepted.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  2*SLICE_W  {plus, minus}; valid one cycle after rd_en.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  SLICE_W  two's-complement difference slice.
- out_last  out  1  marks the final slice; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- sign  out  1  remainder is negative; held until the next accepted start.
- zero  out  1  remainder equals 0; held until the next accepted start.

## Operation
- FSM states: IDLE, FETCH, CALC, SEND, FIN.
- IDLE:
  - start=1 with num_slices≠0 → FETCH. On entry: idx=0, borrow=0, zacc=1, sign=0, zero=0.
  - start=1 with num_slices=0 → FIN with sign=0, zero=1.
- FETCH: drive rd_en=1, rd_addr=idx → CALC.
- CALC: compute {bout, diff} = plus − minus − borrow, in SLICE_W+1 bits.
  - Register out_data=diff and borrow=bout.
  - Update zacc &= (diff==0).
  - out_last=(idx==num_slices−1). → SEND.
- SEND: out_valid=1, and out_data/out_last stay stable while out_ready=0.
  - On out_ready with a non-final beat: idx++ → FETCH.
  - On out_ready with the final beat: sign=borrow, zero=zacc → FIN.
- FIN: done=1 for one cycle → IDLE.
- Address order: idx 0 is the least-significant slice; the address wraps at 2^ADDR_W. num_slices is ≤ the stored depth by contract.
- start outside IDLE is ignored, with no effect on the run in progress.
- rd_addr holds its last value when rd_en=0.
- Reset, including reset mid-run: FSM=IDLE, idx=0, borrow=0, zacc=1.
- Reset value of every output is 0: rd_en, rd_addr, out_valid, out_data, out_last, busy, done, sign, zero.
- A partially emitted run is abandoned on reset; it is not resumed.

## Timing
- Start accepted at cycle 0. FETCH at cycle 1, CALC at 2, first out_valid at 3.
- Each slice takes FETCH + CALC + SEND: 3 cycles minimum, and SEND extends for every cycle out_ready=0.
- A run with N slices and no backpressure: done is asserted at cycle 3N+1; busy falls at cycle 3N+2.
- sign and zero update in the same cycle FIN is entered, so they are valid together with the done pulse.
- No combinational path from out_ready to out_valid, out_data or rd_*. out_ready affects only next-state logic.

## Structure
- Shared package (div_pkg):
  - SLICE_W and ADDR_W defaults.
  - State enum for IDLE/FETCH/CALC/SEND/FIN.
  - RAM word typedef {plus, minus}, which the RAM writer also uses.
- Sub-module slice_sub_borrow:
  - Purely combinational; inputs plus, minus, bin; outputs diff, bout.
  - Reused by the correction step.
- FSM, counters and flags are kept in the top module. The RAM is external.

## Test plan
- N=2; addr0={3,5}, addr1={0,0}, out_ready=1 → beats E then F (last); sign=1, zero=0; done at cycle 7.
- N=3; all slices {A,A} → three beats of 0; sign=0, zero=1; last only on the third beat.
- N=1, {7,2}, out_ready held low for 5 cycles in SEND → out_data=5 stays stable with out_valid=1, and there is no RAM read during the stall.
- N=0 start → no rd_en, no out_valid; done at cycle 1; zero=1, sign=0.
- start pulsed during SEND of an N=2 run → ignored; output matches the case without the pulse.
- rst_n asserted in CALC → all outputs 0 asynchronously; a fresh start then runs correctly from idx 0.
